// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite RAM slave: parametrised width/depth, byte-lane strobes, AW/W in any order,
// and SLVERR for word indices past the end of the RAM.
module axi_lite_ram_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 32
) (
    input  logic                      s_clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [1:0]                wr_state_dbg,
    output logic                      rd_state_dbg
);

    // Every channel transfers when VALID and READY are both high at a rising s_clk edge;
    // a raised VALID and its payload stay stable until that handshake completes.

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_HAVE_A, WR_HAVE_W, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a >> LSB) < 32'(MEM_DEPTH);
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return MEM_AW'(a >> LSB);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    wr_state_t             wr_state, wr_next;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic [1:0]            bresp_q;
    logic                  aw_hs, w_hs, commit;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_data;
    logic [STRB_W-1:0]     c_strb;

    rd_state_t             rd_state, rd_next;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  ar_hs;

    assign AWREADY = (wr_state == WR_IDLE) || (wr_state == WR_HAVE_W);
    assign WREADY  = (wr_state == WR_IDLE) || (wr_state == WR_HAVE_A);
    assign BVALID  = (wr_state == WR_RESP);
    assign BRESP   = bresp_q;
    assign ARREADY = (rd_state == RD_IDLE);
    assign RVALID  = (rd_state == RD_DATA);
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    assign wr_state_dbg = wr_state;
    assign rd_state_dbg = rd_state;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // The commit source mixes live bus inputs with whichever half was latched earlier.
    always_comb begin
        wr_next = wr_state;
        commit  = 1'b0;
        c_addr  = aw_addr_q;
        c_data  = w_data_q;
        c_strb  = w_strb_q;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit  = 1'b1;
                    c_addr  = AWADDR;
                    c_data  = WDATA;
                    c_strb  = WSTRB;
                    wr_next = WR_RESP;
                end else if (aw_hs) begin
                    wr_next = WR_HAVE_A;
                end else if (w_hs) begin
                    wr_next = WR_HAVE_W;
                end
            end
            WR_HAVE_A: begin
                if (w_hs) begin
                    commit  = 1'b1;
                    c_data  = WDATA;
                    c_strb  = WSTRB;
                    wr_next = WR_RESP;
                end
            end
            WR_HAVE_W: begin
                if (aw_hs) begin
                    commit  = 1'b1;
                    c_addr  = AWADDR;
                    wr_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BREADY) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge s_clk) begin
        if (rst) begin
            wr_state  <= WR_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            wr_state <= wr_next;
            if (aw_hs) aw_addr_q <= AWADDR;
            if (w_hs) begin
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            if (commit) bresp_q <= in_range(c_addr) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // RAM is never reset; a reset edge also cancels any commit on that edge.
    always_ff @(posedge s_clk) begin
        if (commit && !rst && in_range(c_addr)) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (c_strb[i]) mem[word_idx(c_addr)][i*8 +: 8] <= c_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_next = RD_DATA;
            RD_DATA: if (RREADY) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    // Non-blocking RAM update means a same-edge read sees the pre-write word.
    always_ff @(posedge s_clk) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            if (ar_hs) begin
                if (in_range(ARADDR)) begin
                    rdata_q <= mem[word_idx(ARADDR)];
                    rresp_q <= RESP_OKAY;
                end else begin
                    rdata_q <= '0;
                    rresp_q <= RESP_SLVERR;
                end
            end
        end
    end

endmodule
